// File: rtl/cv_weights_read_sched.sv
// Weights-buffer read sequencer for one conv layer: walks rows x passes, drives BRAM enable/address
// and emits valid/last/final strobes aligned with the 1-cycle BRAM read latency.
module cv_weights_read_sched #(
    parameter int unsigned ADR_W = 11,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ADR_W-1:0] cfg_base_i,
    input  logic [CNT_W-1:0] cfg_rows_i,
    input  logic [CNT_W-1:0] cfg_passes_i,
    input  logic             stall_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [ADR_W-1:0] rd_adr_o,
    output logic             vec_valid_o,
    output logic             vec_last_o,
    output logic             vec_final_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   rows_q, rows_d;
    logic [CNT_W-1:0]   passes_q, passes_d;
    logic [ADR_W-1:0]   base_q, base_d;
    logic [ADR_W-1:0]   rd_adr_q, rd_adr_d;
    logic               vec_valid_q, vec_last_q, vec_final_q;
    logic               rd_en;
    logic               issue_last;
    logic               issue_final;
    logic               done;

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        rows_d      = rows_q;
        passes_d    = passes_q;
        base_d      = base_q;
        rd_adr_d    = rd_adr_q;
        rd_en       = 1'b0;
        issue_last  = 1'b0;
        issue_final = 1'b0;
        done        = 1'b0;

        if (abort_i) begin
            state_d    = StIdle;
            row_cnt_d  = '0;
            pass_cnt_d = '0;
            rd_adr_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        base_d     = cfg_base_i;
                        rows_d     = cfg_rows_i;
                        passes_d   = cfg_passes_i;
                        row_cnt_d  = '0;
                        pass_cnt_d = '0;
                        rd_adr_d   = cfg_base_i;
                        // An empty layer still passes through DRAIN so start-to-done is 2 cycles.
                        if (cfg_rows_i == '0 || cfg_passes_i == '0) begin
                            state_d = StDrain;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    if (!stall_i) begin
                        rd_en       = 1'b1;
                        issue_last  = (row_cnt_q == rows_q - CNT_W'(1));
                        issue_final = issue_last && (pass_cnt_q == passes_q - CNT_W'(1));
                        if (issue_last) begin
                            row_cnt_d  = '0;
                            pass_cnt_d = pass_cnt_q + CNT_W'(1);
                        end else begin
                            row_cnt_d = row_cnt_q + CNT_W'(1);
                        end
                        if (issue_final) begin
                            pass_cnt_d = '0;
                            state_d    = StDrain;
                        end
                        // Address wraps modulo 2^ADR_W by truncation.
                        rd_adr_d = base_q + ADR_W'(row_cnt_d);
                    end
                end
                StDrain: begin
                    state_d = StDone;
                end
                StDone: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            row_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            rows_q      <= '0;
            passes_q    <= '0;
            base_q      <= '0;
            rd_adr_q    <= '0;
            vec_valid_q <= 1'b0;
            vec_last_q  <= 1'b0;
            vec_final_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            rows_q      <= rows_d;
            passes_q    <= passes_d;
            base_q      <= base_d;
            rd_adr_q    <= rd_adr_d;
            vec_valid_q <= rd_en;
            vec_last_q  <= rd_en & issue_last;
            vec_final_q <= rd_en & issue_final;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done;
    assign rd_en_o     = rd_en;
    assign rd_adr_o    = rd_adr_q;
    assign vec_valid_o = vec_valid_q;
    assign vec_last_o  = vec_last_q;
    assign vec_final_o = vec_final_q;

endmodule

// File: tb/tb_cv_weights_read_sched.sv
// Bench for cv_weights_read_sched: table-driven layer runs with a read scoreboard,
// plus hand-written abort and mid-run reset sequences.
module tb_cv_weights_read_sched;

    localparam int unsigned ADR_W = 11;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [ADR_W-1:0] cfg_base;
    logic [CNT_W-1:0] cfg_rows;
    logic [CNT_W-1:0] cfg_passes;
    logic             stall;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [ADR_W-1:0] rd_adr;
    logic             vec_valid;
    logic             vec_last;
    logic             vec_final;

    int n_cmp = 0;
    int n_bad = 0;

    cv_weights_read_sched #(
        .ADR_W(ADR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .cfg_base_i  (cfg_base),
        .cfg_rows_i  (cfg_rows),
        .cfg_passes_i(cfg_passes),
        .stall_i     (stall),
        .busy_o      (busy),
        .done_o      (done),
        .rd_en_o     (rd_en),
        .rd_adr_o    (rd_adr),
        .vec_valid_o (vec_valid),
        .vec_last_o  (vec_last),
        .vec_final_o (vec_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADR_W-1:0] adr;
        bit               last;
        bit               fin;
    } rd_t;

    typedef struct {
        logic [ADR_W-1:0] base;
        int               rows;
        int               passes;
        int               stall_at;
        int               stall_len;
        bit               poke;
        int               exp_issues;
        int               exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_layer(input vec_t v);
        rd_t q[$];
        rd_t e;
        rd_t pend_e;
        bit  pend;
        int  issued;
        int  stalled;
        int  dones;
        int  done_at;
        int  model_done;
        int  eff_stall;

        for (int p = 0; p < v.passes; p++) begin
            for (int r = 0; r < v.rows; r++) begin
                e.adr  = ADR_W'(int'(v.base) + r);
                e.last = (r == v.rows - 1);
                e.fin  = (r == v.rows - 1) && (p == v.passes - 1);
                q.push_back(e);
            end
        end
        eff_stall  = (v.stall_at < q.size()) ? v.stall_len : 0;
        model_done = (q.size() == 0) ? 2 : q.size() + eff_stall + 2;
        check("issue_count_model", q.size(), v.exp_issues);
        check("done_cycle_model", model_done, v.exp_done);

        @(negedge clk);
        start      = 1'b1;
        cfg_base   = v.base;
        cfg_rows   = CNT_W'(v.rows);
        cfg_passes = CNT_W'(v.passes);
        stall      = 1'b0;
        #1;
        check("idle_busy_before_start", busy, 0);

        pend    = 0;
        issued  = 0;
        stalled = 0;
        dones   = 0;
        done_at = -1;
        for (int cyc = 1; cyc <= v.exp_done + 2; cyc++) begin
            @(negedge clk);
            start      = v.poke && (cyc == 3 || cyc == v.exp_done);
            // Scramble cfg after the latch to prove it is not re-sampled.
            cfg_base   = ADR_W'($urandom);
            cfg_rows   = CNT_W'($urandom_range(0, 9));
            cfg_passes = CNT_W'($urandom_range(0, 9));
            stall      = (issued == v.stall_at) && (stalled < v.stall_len);
            #1;
            check("vec_valid", vec_valid, pend);
            check("vec_last", vec_last, pend && pend_e.last);
            check("vec_final", vec_final, pend && pend_e.fin);
            pend = 0;
            if (stall) begin
                stalled++;
                check("rd_en_under_stall", rd_en, 0);
                if (q.size() > 0) check("rd_adr_held", rd_adr, q[0].adr);
            end else if (rd_en) begin
                if (q.size() == 0) begin
                    check("unexpected_rd_en", 1, 0);
                end else begin
                    pend_e = q.pop_front();
                    pend   = 1;
                    issued++;
                    check("rd_adr", rd_adr, pend_e.adr);
                end
            end
            if (done) begin
                dones++;
                done_at = cyc;
            end
            check("busy", busy, cyc <= v.exp_done);
        end
        check("issued", issued, v.exp_issues);
        check("reads_left", q.size(), 0);
        check("done_pulses", dones, 1);
        check("done_cycle", done_at, v.exp_done);
        start = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        cfg_base   = '0;
        cfg_rows   = '0;
        cfg_passes = '0;

        vecs[0] = '{11'h010, 4, 2, 99, 0, 0, 8, 10};
        vecs[1] = '{11'h010, 4, 2, 2,  3, 0, 8, 13};
        vecs[2] = '{11'h7FE, 4, 1, 99, 0, 0, 4, 6};
        vecs[3] = '{11'h000, 0, 5, 99, 0, 0, 0, 2};
        vecs[4] = '{11'h100, 3, 0, 99, 0, 0, 0, 2};
        vecs[5] = '{11'h020, 1, 3, 99, 0, 1, 3, 5};
        vecs[6] = '{11'h7FF, 2, 2, 0,  2, 0, 4, 8};
        vecs[7] = '{11'h3A0, 5, 1, 4,  1, 0, 5, 8};
        vecs[8] = '{11'h055, 3, 2, 1,  4, 1, 6, 12};

        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_rd_adr", rd_adr, 0);
        check("reset_vec_valid", vec_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_layer(vecs[i]);

        // Abort on the 3rd RUN cycle of an 8-row layer.
        @(negedge clk);
        start = 1'b1; cfg_base = 11'h040; cfg_rows = 16'd8; cfg_passes = 16'd1;
        @(negedge clk);
        start = 1'b0; #1;
        check("abort_rd_en_c1", rd_en, 1);
        check("abort_rd_adr_c1", rd_adr, 11'h040);
        @(negedge clk); #1;
        check("abort_rd_adr_c2", rd_adr, 11'h041);
        check("abort_vec_valid_c2", vec_valid, 1);
        @(negedge clk);
        abort = 1'b1; #1;
        check("abort_rd_en_forced", rd_en, 0);
        check("abort_vec_valid_c3", vec_valid, 1);
        @(negedge clk);
        abort = 1'b0; #1;
        check("abort_busy_after", busy, 0);
        check("abort_vec_valid_after", vec_valid, 0);
        check("abort_rd_en_after", rd_en, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("abort_no_done", done, 0);
            check("abort_stays_idle", busy, 0);
        end

        // abort and start together in IDLE: start must be dropped.
        @(negedge clk);
        abort = 1'b1; start = 1'b1; cfg_rows = 16'd2; cfg_passes = 16'd1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; #1;
        check("abort_start_busy", busy, 0);
        check("abort_start_rd_en", rd_en, 0);

        // Asynchronous reset mid-run.
        @(negedge clk);
        start = 1'b1; cfg_base = 11'h200; cfg_rows = 16'd6; cfg_passes = 16'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0; #1;
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_rd_adr", rd_adr, 0);
        check("midrst_vec_valid", vec_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("post_reset_no_done", done, 0);
            check("post_reset_idle", busy, 0);
        end

        run_layer(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
